// File: rtl/turbo_scratchpad_slave_pkg.sv
// Shared definitions for the tile-local scratchpad slave: address slot,
// FSM state encoding and store-exclusive status codes.
package turbo_scratchpad_slave_pkg;

    // Tile decode places the scratchpad in the 4 KiB slot 16'hx000 (x = tile nibble).
    localparam logic [15:0] SCRATCHPAD      = 16'h0000;
    localparam int unsigned SLOT_MSB        = 15;
    localparam int unsigned SLOT_LSB        = 12;

    typedef enum logic [1:0] {
        SP_IDLE    = 2'd0,
        SP_RD_WAIT = 2'd1,
        SP_RESP    = 2'd2
    } sp_state_e;

    localparam logic EXCL_OK   = 1'b0;
    localparam logic EXCL_FAIL = 1'b1;

endpackage

// File: rtl/turbo_scratchpad_ram.sv
// Single-port DEPTH x DWIDTH scratchpad array with per-byte write enables
// and a registered read port. Contents are deliberately never reset.
module turbo_scratchpad_ram #(
    parameter int DWIDTH = 128,
    parameter int SWIDTH = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic [SWIDTH-1:0] i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DWIDTH-1:0] i_wdata,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rdata_q;

    // An access with no lane enables is a read; the read port only updates on reads.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < SWIDTH; b++) begin
                if (i_we[b]) begin
                    mem_q[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
            if (i_we == '0) begin
                rdata_q <= mem_q[i_addr];
            end
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/turbo_scratchpad_slave.sv
// Wishbone slave front-end for the tile scratchpad: request FSM,
// single-entry exclusive monitor and response muxing around the RAM.
module turbo_scratchpad_slave
    import turbo_scratchpad_slave_pkg::*;
#(
    parameter int WB_DWIDTH = 128,
    parameter int WB_SWIDTH = 16,
    parameter int DEPTH     = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [31:0]          i_wb_adr,
    input  logic [WB_SWIDTH-1:0] i_wb_sel,
    input  logic                 i_wb_we,
    input  logic [WB_DWIDTH-1:0] i_wb_dat,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_ld_excl,
    output logic [WB_DWIDTH-1:0] o_wb_dat,
    output logic                 o_wb_ack,
    output logic                 o_wb_err
);

    localparam int AW = $clog2(DEPTH);

    sp_state_e             state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [WB_DWIDTH-1:0]  dat_q, dat_d;
    logic                  resv_valid_q, resv_valid_d;
    logic [AW-1:0]         resv_idx_q, resv_idx_d;

    logic [AW-1:0]         req_idx;
    logic                  resv_hit;
    logic                  ram_en;
    logic [WB_SWIDTH-1:0]  ram_we;
    logic [WB_DWIDTH-1:0]  ram_rdata;
    logic                  unused_adr_bits;

    assign req_idx         = i_wb_adr[AW+3:4];
    assign resv_hit        = resv_valid_q && (resv_idx_q == req_idx);
    assign unused_adr_bits = ^{i_wb_adr[31:AW+4], i_wb_adr[3:0]};

    turbo_scratchpad_ram #(
        .DWIDTH (WB_DWIDTH),
        .SWIDTH (WB_SWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_en    (ram_en),
        .i_we    (ram_we),
        .i_addr  (req_idx),
        .i_wdata (i_wb_dat),
        .o_rdata (ram_rdata)
    );

    // Every RAM access and reservation update happens on the accept edge, so
    // later changes on the bus inputs cannot alter an access in flight.
    always_comb begin
        state_d      = state_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        dat_d        = '0;
        resv_valid_d = resv_valid_q;
        resv_idx_d   = resv_idx_q;
        ram_en       = 1'b0;
        ram_we       = '0;

        case (state_q)
            SP_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    if (i_wb_sel == '0) begin
                        err_d   = 1'b1;
                        state_d = SP_RESP;
                    end else if (!i_wb_we) begin
                        ram_en  = 1'b1;
                        state_d = SP_RD_WAIT;
                        if (i_ld_excl) begin
                            resv_valid_d = 1'b1;
                            resv_idx_d   = req_idx;
                        end
                    end else begin
                        ack_d   = 1'b1;
                        state_d = SP_RESP;
                        if (!i_ld_excl || resv_hit) begin
                            ram_en = 1'b1;
                            ram_we = i_wb_sel;
                        end
                        if (i_ld_excl && !resv_hit) begin
                            dat_d = {{(WB_DWIDTH-1){1'b0}}, EXCL_FAIL};
                        end
                        if (i_ld_excl || resv_hit) begin
                            resv_valid_d = 1'b0;
                        end
                    end
                end
            end
            SP_RD_WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = SP_IDLE;
                end else begin
                    ack_d   = 1'b1;
                    dat_d   = ram_rdata;
                    state_d = SP_RESP;
                end
            end
            SP_RESP: begin
                state_d = SP_IDLE;
            end
            default: begin
                state_d = SP_IDLE;
            end
        endcase

        if (i_rst) begin
            ram_en = 1'b0;
            ram_we = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= SP_IDLE;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            dat_q        <= '0;
            resv_valid_q <= 1'b0;
            resv_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            dat_q        <= dat_d;
            resv_valid_q <= resv_valid_d;
            resv_idx_q   <= resv_idx_d;
        end
    end

    // A master dropping cyc during RESP must not see the response.
    assign o_wb_ack = ack_q && i_wb_cyc;
    assign o_wb_err = err_q && i_wb_cyc;
    assign o_wb_dat = o_wb_ack ? dat_q : '0;

endmodule

// File: tb/tb_turbo_scratchpad_slave.sv
// Scoreboard bench for turbo_scratchpad_slave: a shadow memory and
// reservation model predict each response, which is compared on arrival.
module tb_turbo_scratchpad_slave;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  wbAdr;
    logic [15:0]  wbSel;
    logic         wbWe;
    logic [127:0] wbDat;
    logic         wbCyc;
    logic         wbStb;
    logic         ldExcl;
    logic [127:0] rdDat;
    logic         ack;
    logic         err;

    always #5 clk = ~clk;

    turbo_scratchpad_slave #(
        .WB_DWIDTH (128),
        .WB_SWIDTH (16),
        .DEPTH     (256)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wb_adr  (wbAdr),
        .i_wb_sel  (wbSel),
        .i_wb_we   (wbWe),
        .i_wb_dat  (wbDat),
        .i_wb_cyc  (wbCyc),
        .i_wb_stb  (wbStb),
        .i_ld_excl (ldExcl),
        .o_wb_dat  (rdDat),
        .o_wb_ack  (ack),
        .o_wb_err  (err)
    );

    typedef struct {
        logic         err;
        logic [127:0] dat;
        int           lat;
    } expItem_t;

    int           vectorCount = 0;
    int           miscompareCount = 0;
    expItem_t     expQ[$];
    logic [127:0] shadow [0:255];
    logic         resvValid;
    logic [7:0]   resvIdx;

    // Single comparison point: counts every vector and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference behaviour of one accepted request against the shadow state.
    task automatic modelAccess(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                               input logic [127:0] dat, input logic excl, output expItem_t item);
        logic [7:0] idx;
        logic       doWrite;
        idx      = adr[11:4];
        doWrite  = 1'b0;
        item.err = 1'b0;
        item.dat = '0;
        item.lat = 1;
        if (sel == 16'h0) begin
            item.err = 1'b1;
        end else if (!we) begin
            item.dat = shadow[idx];
            item.lat = 2;
            if (excl) begin
                resvValid = 1'b1;
                resvIdx   = idx;
            end
        end else if (excl) begin
            if (resvValid && resvIdx == idx) doWrite = 1'b1;
            else item.dat = 128'h1;
            resvValid = 1'b0;
        end else begin
            doWrite = 1'b1;
            if (resvValid && resvIdx == idx) resvValid = 1'b0;
        end
        if (doWrite) begin
            for (int b = 0; b < 16; b++) begin
                if (sel[b]) shadow[idx][b*8 +: 8] = dat[b*8 +: 8];
            end
        end
    endtask

    // One complete bus transaction: predict, drive, scramble inputs after accept, compare.
    task automatic applyStimulus(input string tag, input logic we, input logic [31:0] adr,
                                 input logic [15:0] sel, input logic [127:0] dat, input logic excl);
        expItem_t item;
        expItem_t got;
        int       lat;
        logic     seenAck;
        logic     seenErr;
        logic [127:0] seenDat;
        @(negedge clk);
        checkOutput({tag, "_idle_resp"}, {126'b0, ack, err}, '0);
        checkOutput({tag, "_idle_dat"}, rdDat, '0);
        modelAccess(we, adr, sel, dat, excl, item);
        expQ.push_back(item);
        wbCyc  = 1'b1;
        wbStb  = 1'b1;
        wbWe   = we;
        wbAdr  = adr;
        wbSel  = sel;
        wbDat  = dat;
        ldExcl = excl;
        @(posedge clk);
        #1;
        wbStb  = 1'b0;
        wbWe   = ~we;
        wbAdr  = $urandom;
        wbSel  = 16'($urandom);
        wbDat  = {$urandom, $urandom, $urandom, $urandom};
        ldExcl = ~excl;
        lat     = 0;
        seenAck = 1'b0;
        seenErr = 1'b0;
        seenDat = '0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (ack || err) begin
                lat     = n;
                seenAck = ack;
                seenErr = err;
                seenDat = rdDat;
                break;
            end
        end
        got = expQ.pop_front();
        checkOutput({tag, "_latency"}, 128'(lat), 128'(got.lat));
        checkOutput({tag, "_ack"}, {127'b0, seenAck}, {127'b0, ~got.err});
        checkOutput({tag, "_err"}, {127'b0, seenErr}, {127'b0, got.err});
        checkOutput({tag, "_dat"}, seenDat, got.dat);
        @(posedge clk);
        #1;
        wbCyc  = 1'b0;
        wbWe   = 1'b0;
        wbSel  = '0;
        ldExcl = 1'b0;
    endtask

    task automatic doWrite(input string tag, input logic [31:0] adr, input logic [15:0] sel,
                           input logic [127:0] dat, input logic excl);
        applyStimulus(tag, 1'b1, adr, sel, dat, excl);
    endtask

    task automatic doRead(input string tag, input logic [31:0] adr, input logic excl);
        applyStimulus(tag, 1'b0, adr, 16'hFFFF, '0, excl);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         respCount;
        int         ackCount;
        int         errCount;
        expItem_t   dummy;
        rst       = 1'b1;
        wbCyc     = 1'b0;
        wbStb     = 1'b0;
        wbWe      = 1'b0;
        wbAdr     = '0;
        wbSel     = '0;
        wbDat     = '0;
        ldExcl    = 1'b0;
        resvValid = 1'b0;
        resvIdx   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ack", {127'b0, ack}, '0);
        checkOutput("reset_err", {127'b0, err}, '0);
        checkOutput("reset_dat", rdDat, '0);
        rst = 1'b0;

        doWrite("wr_a5", 32'h0000_0010, 16'hFFFF, {16{8'hA5}}, 1'b0);
        doRead("rd_a5", 32'h0000_0010, 1'b0);

        doWrite("wr_zero50", 32'h0000_0050, 16'hFFFF, '0, 1'b0);
        doWrite("wr_lanes", 32'h0000_0050, 16'h000F, {128{1'b1}}, 1'b0);
        doRead("rd_lanes", 32'h0000_0050, 1'b0);
        doWrite("wr_nosel", 32'h0000_0050, 16'h0000, {128{1'b1}}, 1'b0);
        doRead("rd_nosel", 32'h0000_0050, 1'b0);
        applyStimulus("rd_nosel_err", 1'b0, 32'h0000_0050, 16'h0000, '0, 1'b0);

        doWrite("wr_zero20", 32'h0000_0020, 16'hFFFF, '0, 1'b0);
        doWrite("wr_zero30", 32'h0000_0030, 16'hFFFF, '0, 1'b0);
        doWrite("strex_cold", 32'h0000_0020, 16'hFFFF, 128'h33, 1'b1);
        doRead("ldrex_20", 32'h0000_0020, 1'b1);
        doWrite("strex_ok", 32'h0000_0020, 16'hFFFF, 128'h55, 1'b1);
        doRead("rd_55", 32'h0000_0020, 1'b0);
        doWrite("strex_again", 32'h0000_0020, 16'hFFFF, 128'h77, 1'b1);
        doRead("rd_still55", 32'h0000_0020, 1'b0);

        doRead("ldrex_b", 32'h0000_0020, 1'b1);
        doWrite("plain_same", 32'h0000_0020, 16'hFFFF, 128'h66, 1'b0);
        doWrite("strex_broken", 32'h0000_0020, 16'hFFFF, 128'h99, 1'b1);
        doRead("rd_66", 32'h0000_0020, 1'b0);
        doRead("ldrex_c", 32'h0000_0020, 1'b1);
        doWrite("plain_other", 32'h0000_0030, 16'hFFFF, 128'h11, 1'b0);
        doWrite("strex_kept", 32'h0000_0020, 16'hFFFF, 128'hAA, 1'b1);
        doRead("rd_aa", 32'h0000_0020, 1'b0);

        // Back-to-back writes with stb held: one ack every second cycle.
        @(negedge clk);
        modelAccess(1'b1, 32'h0000_0040, 16'hFFFF, 128'hC0FFEE, 1'b0, dummy);
        wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b1;
        wbAdr = 32'h0000_0040; wbSel = 16'hFFFF; wbDat = 128'hC0FFEE; ldExcl = 1'b0;
        ackCount = 0;
        errCount = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ack) ackCount++;
            if (err) errCount++;
        end
        wbCyc = 1'b0; wbStb = 1'b0; wbWe = 1'b0; wbSel = '0;
        checkOutput("b2b_ack_count", 128'(ackCount), 128'd4);
        checkOutput("b2b_err_count", 128'(errCount), 128'd0);
        doRead("rd_b2b", 32'h0000_0040, 1'b0);

        doRead("ldrex_20_mv", 32'h0000_0020, 1'b1);
        doRead("ldrex_40_mv", 32'h0000_0040, 1'b1);
        doWrite("strex_moved", 32'h0000_0020, 16'hFFFF, 128'hBB, 1'b1);
        doRead("ldrex_40_b", 32'h0000_0040, 1'b1);
        doWrite("strex_40", 32'h0000_0040, 16'hFFFF, 128'hDD, 1'b1);
        doRead("rd_dd", 32'h0000_0040, 1'b0);

        // Read aborted in RD_WAIT; cyc comes back idle so a stray ack would show.
        @(negedge clk);
        wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b0;
        wbAdr = 32'h0000_0010; wbSel = 16'hFFFF; ldExcl = 1'b0;
        @(posedge clk);
        #1;
        wbStb = 1'b0;
        respCount = 0;
        @(negedge clk);
        if (ack || err) respCount++;
        wbCyc = 1'b0;
        @(posedge clk);
        #1;
        wbCyc = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack || err) respCount++;
        end
        wbCyc = 1'b0;
        checkOutput("abort_no_resp", 128'(respCount), 128'd0);

        // Reset during a load-exclusive read must drop the response and the reservation.
        @(negedge clk);
        wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b0;
        wbAdr = 32'h0000_0020; wbSel = 16'hFFFF; ldExcl = 1'b1;
        @(posedge clk);
        #1;
        wbStb = 1'b0; ldExcl = 1'b0; rst = 1'b1;
        respCount = 0;
        @(negedge clk);
        if (ack || err) respCount++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack || err) respCount++;
        end
        wbCyc = 1'b0;
        resvValid = 1'b0;
        checkOutput("rst_no_resp", 128'(respCount), 128'd0);
        doWrite("strex_after_rst", 32'h0000_0020, 16'hFFFF, 128'hEE, 1'b1);
        doRead("rd_after_rst", 32'h0000_0020, 1'b0);

        // stb without cyc must be ignored entirely.
        @(negedge clk);
        wbCyc = 1'b0; wbStb = 1'b1; wbWe = 1'b1;
        wbAdr = 32'h0000_0010; wbSel = 16'hFFFF; wbDat = '0;
        respCount = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack || err) respCount++;
        end
        wbStb = 1'b0; wbWe = 1'b0; wbSel = '0;
        checkOutput("stb_only_resp", 128'(respCount), 128'd0);
        doRead("rd_stb_only", 32'h0000_0010, 1'b0);

        checkOutput("scoreboard_empty", 128'(expQ.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
